// File: rtl/inst_encoder.sv
// MIPS-style instruction encoder feeding instruction memory through a 4-deep FIFO.
// Optional ENC_ILLEGAL_CHECK_EN: flag and drop req_op 13-15 instead of encoding as ADD.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [25:0] req_imm,
  input  logic        req_last,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic [15:0] words_written,
  output logic        err_illegal
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] fifo [4];
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic [31:0] word;
  logic [25:0] rfmt, ifmt;
  logic        accept, push, pop, load;

  assign rfmt = {req_rs, req_rt, req_rd, 5'h00, 6'h00} >> 6;
  assign ifmt = {req_rs, req_rt, req_imm[15:0]};

  always_comb begin
    word = {6'h00, rfmt[19:0], 6'h20};
    unique case (req_op)
      4'd0:    word = {6'h00, rfmt[19:0], 6'h20};
      4'd1:    word = {6'h00, rfmt[19:0], 6'h22};
      4'd2:    word = {6'h00, rfmt[19:0], 6'h24};
      4'd3:    word = {6'h00, rfmt[19:0], 6'h25};
      4'd4:    word = {6'h00, rfmt[19:0], 6'h2A};
      4'd5:    word = {6'h00, req_rs, 15'h0000, 6'h08};
      4'd6:    word = {6'h08, ifmt};
      4'd7:    word = {6'h0A, ifmt};
      4'd8:    word = {6'h23, ifmt};
      4'd9:    word = {6'h2B, ifmt};
      4'd10:   word = {6'h04, ifmt};
      4'd11:   word = {6'h02, req_imm};
      4'd12:   word = {6'h03, req_imm};
      default: word = {6'h00, rfmt[19:0], 6'h20};
    endcase
  end

  assign req_ready = (state == RUN) && (cnt < 3'd4);
  assign accept    = req_valid && req_ready;
  assign mem_we    = ((state == RUN) || (state == DRAIN)) && (cnt != 3'd0);
  assign pop       = mem_we && mem_ready;
  assign load      = start && (state == IDLE);
  assign done      = (state == DONE);
  assign mem_wdata = (cnt != 3'd0) ? fifo[rp] : 32'h0;

`ifdef ENC_ILLEGAL_CHECK_EN
  logic bad;
  assign bad  = (req_op > 4'd12);
  assign push = accept && !bad;

  always_ff @(posedge clk) begin
    if (rst)
      err_illegal <= 1'b0;
    else if (load)
      err_illegal <= 1'b0;
    else if (accept && bad)
      err_illegal <= 1'b1;
  end
`else
  assign push        = accept;
  assign err_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push)
      fifo[wp] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      cnt <= 3'd0;
    end else begin
      if (push)
        wp <= wp + 2'd1;
      if (pop)
        rp <= rp + 2'd1;
      cnt <= cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr      <= 32'h0;
      words_written <= 16'h0;
    end else if (load) begin
      mem_addr      <= base_addr;
      words_written <= 16'h0;
    end else if (pop) begin
      mem_addr      <= mem_addr + 32'd4;
      words_written <= words_written + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (accept && req_last) state_n = DRAIN;
      DRAIN: if (cnt == 3'd0) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table, scoreboard of memory writes,
// plus stall, address-wrap, reset-abort and illegal-op sequences.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, start, req_valid, req_ready, req_last;
  logic [31:0] base_addr, mem_addr, mem_wdata;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [25:0] req_imm;
  logic        mem_we, mem_ready, done, err_illegal;
  logic [15:0] words_written;

  inst_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_last(req_last), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .words_written(words_written), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         sbq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] exp_addr;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_a, prev_d;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard and hold-stability monitor
  always @(negedge clk) begin
    if (prev_stall && mem_we) begin
      chk("hold_addr", mem_addr, prev_a);
      chk("hold_data", mem_wdata, prev_d);
    end
    prev_stall = mem_we && !mem_ready && !rst;
    prev_a = mem_addr;
    prev_d = mem_wdata;
    if (mem_we && mem_ready && !rst) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = sbq.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", mem_wdata, w.d);
      end
    end
  end

  task automatic do_start(input logic [31:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    exp_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [25:0] imm, input logic last,
                      input logic [31:0] exp, input bit wr);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_last = last; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      nvec++;
      nerr++;
      $display("FAIL req_timeout: req_ready 0 want 1");
    end else if (wr) begin
      sbq.push_back('{a: exp_addr, d: exp});
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic wait_done(input logic [15:0] ww);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done", {31'h0, done}, 32'h1);
    chk("words_written", {16'h0, words_written}, {16'h0, ww});
    chk("sb_empty", sbq.size(), 32'h0);
    @(negedge clk);
    chk("done_pulse", {31'h0, done}, 32'h0);
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{4'd0,  5'd1,  5'd2, 5'd3, 26'h0,       32'h00221820};
    tbl[1]  = '{4'd1,  5'd1,  5'd2, 5'd3, 26'h0,       32'h00221822};
    tbl[2]  = '{4'd2,  5'd1,  5'd2, 5'd3, 26'h0,       32'h00221824};
    tbl[3]  = '{4'd3,  5'd1,  5'd2, 5'd3, 26'h0,       32'h00221825};
    tbl[4]  = '{4'd4,  5'd1,  5'd2, 5'd3, 26'h0,       32'h0022182A};
    tbl[5]  = '{4'd5,  5'd31, 5'd5, 5'd6, 26'h3FFFFFF, 32'h03E00008};
    tbl[6]  = '{4'd6,  5'd0,  5'd5, 5'd9, 26'h3FF0010, 32'h20050010};
    tbl[7]  = '{4'd8,  5'd29, 5'd8, 5'd0, 26'hFFFC,    32'h8FA8FFFC};
    tbl[8]  = '{4'd10, 5'd1,  5'd2, 5'd0, 26'hFFFF,    32'h1022FFFF};
    tbl[9]  = '{4'd11, 5'd7,  5'd7, 5'd7, 26'h40,      32'h08000040};
    tbl[10] = '{4'd12, 5'd0,  5'd0, 5'd0, 26'h100,     32'h0C000100};
    tbl[11] = '{4'd7,  5'd3,  5'd4, 5'd0, 26'h1234,    32'h28641234};
    tbl[12] = '{4'd9,  5'd2,  5'd7, 5'd0, 26'h0008,    32'hAC470008};
    tbl[13] = '{4'd0,  5'd31, 5'd31, 5'd31, 26'h0,     32'h03FFF820};

    rst = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0;
    req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
    req_last = 1'b0; mem_ready = 1'b1; exp_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ww", {16'h0, words_written}, 32'h0);
    chk("rst_err", {31'h0, err_illegal}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single-word program
    do_start(32'h0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h00221820, 1'b1);
    wait_done(16'd1);

    // full vector table as one program
    do_start(32'h100);
    for (int i = 0; i < 14; i++)
      send(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm,
           (i == 13), tbl[i].exp, 1'b1);
    wait_done(16'd14);

    // back-pressure: FIFO fills, writes held, then drains in order
    mem_ready = 1'b0;
    do_start(32'h400);
    for (int i = 0; i < 4; i++)
      send(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm,
           1'b0, tbl[i].exp, 1'b1);
    @(negedge clk);
    chk("full_ready", {31'h0, req_ready}, 32'h0);
    chk("full_we", {31'h0, mem_we}, 32'h1);
    chk("full_wdata", mem_wdata, 32'h00221820);
    chk("full_addr", mem_addr, 32'h400);
    repeat (3) @(negedge clk);
    fork
      begin
        send(tbl[4].op, tbl[4].rs, tbl[4].rt, tbl[4].rd, tbl[4].imm,
             1'b0, tbl[4].exp, 1'b1);
        send(tbl[5].op, tbl[5].rs, tbl[5].rt, tbl[5].rd, tbl[5].imm,
             1'b1, tbl[5].exp, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
    join
    wait_done(16'd6);

    // address wrap
    do_start(32'hFFFFFFFC);
    send(tbl[9].op, 5'd0, 5'd0, 5'd0, tbl[9].imm, 1'b0, tbl[9].exp, 1'b1);
    send(tbl[10].op, 5'd0, 5'd0, 5'd0, tbl[10].imm, 1'b1, tbl[10].exp, 1'b1);
    wait_done(16'd2);

    // illegal opcode
    do_start(32'h800);
`ifdef ENC_ILLEGAL_CHECK_EN
    send(4'd14, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h0, 1'b0);
    wait_done(16'd0);
    chk("err_set", {31'h0, err_illegal}, 32'h1);
    do_start(32'h900);
    @(negedge clk);
    chk("err_clr", {31'h0, err_illegal}, 32'h0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h00221820, 1'b1);
    wait_done(16'd1);
`else
    send(4'd14, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1, 32'h00221820, 1'b1);
    wait_done(16'd1);
    chk("err_tied", {31'h0, err_illegal}, 32'h0);
`endif

    // reset with 3 words buffered discards them
    mem_ready = 1'b0;
    do_start(32'h200);
    for (int i = 0; i < 3; i++)
      send(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm,
           1'b0, tbl[i].exp, 1'b0);
    @(negedge clk);
    chk("pre_rst_we", {31'h0, mem_we}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_we", {31'h0, mem_we}, 32'h0);
    chk("post_rst_ww", {16'h0, words_written}, 32'h0);
    chk("post_rst_addr", mem_addr, 32'h0);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h0);
    mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle_we", {31'h0, mem_we}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Clock and reset SHALL be one clock and a synchronous, active-high reset; port list follows, clock and reset first.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle pulse; loads base_addr and begins a program load.
REQ-005 base_addr  in  32  byte address of first instruction word.
REQ-006 req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both high on a clk edge.
REQ-007 req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 ADDI, 7 SLTI, 8 LW, 9 SW, 10 BEQ, 11 J, 12 JAL; 13-15 illegal.
REQ-008 req_rs / req_rt / req_rd  in  5 each  register fields.
REQ-009 req_imm  in  26  bits[15:0] are the I-type immediate; bits[25:0] are the J-type target.
REQ-010 req_last  in  1  qualifies the final request of the program.
REQ-011 mem_we / mem_ready  out / in  1 / 1  instruction-memory write handshake.
REQ-012 mem_addr / mem_wdata  out  32 / 32  write address and encoded instruction word.
REQ-013 done  out  1  one-cycle pulse when the load completes.
REQ-014 words_written  out  16  count of words accepted by memory since the last start.
REQ-015 err_illegal  out  1  sticky illegal-op flag; see Configuration.

Function
REQ-016 Encoding, R-type (ADD/SUB/AND/OR/SLT) SHALL be {6'h00, rs, rt, rd, 5'h00, funct}, with funct 0x20/0x22/0x24/0x25/0x2A respectively.
REQ-017 Encoding, JR SHALL be {6'h00, rs, 5'h00, 5'h00, 5'h00, 6'h08}.
REQ-018 Encoding, I-type SHALL be {opcode, rs, rt, imm[15:0]}, with opcode ADDI 0x08, SLTI 0x0A, LW 0x23, SW 0x2B, BEQ 0x04.
REQ-019 Encoding, J/JAL SHALL be {opcode, imm[25:0]}, with opcode 0x02/0x03; unused request fields SHALL be ignored.
REQ-020 Encoded words SHALL pass through a 4-entry FIFO; a word accepted in cycle N SHALL appear on mem_wdata no earlier than cycle N+1.
REQ-021 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on start.
- RUN->DRAIN on acceptance of a request with req_last=1.
- DRAIN->DONE when the FIFO is empty.
- DONE->IDLE after one cycle.
REQ-022 req_ready SHALL be high only in RUN with FIFO occupancy < 4.
REQ-023 On start in IDLE: mem_addr := base_addr and words_written := 0; start outside IDLE SHALL be ignored.
REQ-024 mem_we SHALL be high in RUN or DRAIN whenever the FIFO is non-empty.
REQ-025 While mem_we=1 and mem_ready=0, mem_addr and mem_wdata SHALL be held stable.
REQ-026 On a write transfer: pop the FIFO, mem_addr += 4 (modulo 2^32 wrap), words_written += 1 (wraps at 16 bits).
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged; a full FIFO SHALL accept no push; an empty FIFO SHALL hold mem_we low.
REQ-028 done SHALL be high only in DONE.
REQ-029 An empty program SHALL be impossible: req_last on the first request gives a 1-word load.

Reset
REQ-030 rst SHALL force:
- state IDLE, FIFO empty;
- mem_addr=0, mem_wdata=0, mem_we=0;
- req_ready=0, done=0, words_written=0, err_illegal=0.
REQ-031 rst mid-load SHALL discard all buffered words without any further write; rst has priority over start and all handshakes.

Configuration
REQ-032 ENC_ILLEGAL_CHECK_EN defined: accepting req_op 13-15 SHALL set err_illegal (cleared only by rst or start), and the request SHALL be consumed but not written.
REQ-033 ENC_ILLEGAL_CHECK_EN undefined: req_op 13-15 SHALL encode as ADD with the given fields, and err_illegal SHALL be tied 0.

Verification
REQ-034 start, base_addr=0x0; ADD rs=1 rt=2 rd=3, last=1; mem_ready=1 -> one write 0x00221820 at 0x0, then done pulse, words_written=1.
REQ-035 Program ADDI rs=0 rt=5 imm=0x0010; LW rs=29 rt=8 imm=0xFFFC; BEQ rs=1 rt=2 imm=0xFFFF, last -> writes 0x20050010@0x100, 0x8FA8FFFC@0x104, 0x1022FFFF@0x108, with base_addr=0x100.
REQ-036 J imm=0x40, JAL imm=0x100, JR rs=31 -> 0x08000040, 0x0C000100, 0x03E00008.
REQ-037 mem_ready=0 while 6 requests are offered -> req_ready drops after 4 accepts and mem_wdata is held; mem_ready=1 -> all 6 words written in order.
REQ-038 base_addr=0xFFFFFFFC, 2 words -> addresses 0xFFFFFFFC then 0x00000000.
REQ-039 rst asserted with 3 words buffered -> mem_we=0 next cycle and no further writes; req_op=14 -> with the macro, err_illegal=1 and no write; without the macro, an ADD encoding is written.
